// File: rtl/segre_pkg.sv
// Shared types and constants for the store-buffer drain path.
package segre_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int WORD_BYTES = WORD_SIZE / 8;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  addr;
        logic [WORD_SIZE-1:0]  data;
        logic [WORD_BYTES-1:0] be;
    } drain_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } drain_state_t;

    // Memory side only ever sees word-aligned addresses.
    function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] addr);
        return addr & ~WORD_SIZE'(3);
    endfunction

endpackage

// File: rtl/segre_byte_merge.sv
// Byte-lane merge: lanes enabled in new_be take new_data, the rest keep old_data.
module segre_byte_merge
    import segre_pkg::*;
(
    input  logic [WORD_SIZE-1:0]  old_data,
    input  logic [WORD_BYTES-1:0] old_be,
    input  logic [WORD_SIZE-1:0]  new_data,
    input  logic [WORD_BYTES-1:0] new_be,
    output logic [WORD_SIZE-1:0]  merged_data,
    output logic [WORD_BYTES-1:0] merged_be
);

    always_comb begin
        merged_data = old_data;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (new_be[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
        end
    end

    assign merged_be = old_be | new_be;

endmodule

// File: rtl/segre_sb_drain_ctrl.sv
// Store-buffer drain controller: two-slot (in-flight F, pending P) write path with ack timeout.
// Optional macro SEGRE_DRAIN_MERGE_EN lets same-word requests merge into the pending slot.
module segre_sb_drain_ctrl
    import segre_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  sb_valid_i,
    input  logic [WORD_SIZE-1:0]  sb_addr_i,
    input  logic [WORD_SIZE-1:0]  sb_data_i,
    input  logic [WORD_BYTES-1:0] sb_be_i,
    output logic                  sb_ready_o,
    output logic                  mem_req_o,
    output logic [WORD_SIZE-1:0]  mem_addr_o,
    output logic [WORD_SIZE-1:0]  mem_data_o,
    output logic [WORD_BYTES-1:0] mem_be_o,
    input  logic                  mem_ack_i,
    output logic                  empty_o,
    output logic                  err_o,
    output logic [1:0]            state_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    drain_state_t     state_q;
    drain_req_t       f_q;
    drain_req_t       p_q;
    logic             p_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             err_q;

    drain_req_t in_req;
    drain_req_t p_next;
    logic       ack;
    logic       accept;
    logic       merge_hit;

    assign in_req = '{addr: word_align(sb_addr_i), data: sb_data_i, be: sb_be_i};
    assign ack    = (state_q == ISSUE) && mem_ack_i;

`ifdef SEGRE_DRAIN_MERGE_EN
    logic [WORD_SIZE-1:0]  merged_data;
    logic [WORD_BYTES-1:0] merged_be;

    // A pending write that is about to move into F can no longer absorb bytes.
    assign merge_hit = p_valid_q && !ack &&
                       (sb_addr_i[WORD_SIZE-1:2] == p_q.addr[WORD_SIZE-1:2]);

    segre_byte_merge u_merge (
        .old_data    (p_q.data),
        .old_be      (p_q.be),
        .new_data    (sb_data_i),
        .new_be      (sb_be_i),
        .merged_data (merged_data),
        .merged_be   (merged_be)
    );

    assign p_next = merge_hit ? '{addr: p_q.addr, data: merged_data, be: merged_be} : in_req;
`else
    assign merge_hit = 1'b0;
    assign p_next    = in_req;
`endif

    // Handshake: a request transfers on any cycle where sb_valid_i && sb_ready_o;
    // the memory write transfers on a cycle where mem_req_o && mem_ack_i.
    assign sb_ready_o = !rsn_i && (state_q != ERROR) && (!p_valid_q || merge_hit);
    assign accept     = sb_valid_i && sb_ready_o;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q   <= IDLE;
            f_q       <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        f_q       <= in_req;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack) begin
                        cnt_q <= '0;
                        if (p_valid_q) begin
                            f_q <= p_q;
                            if (accept) p_q <= in_req;
                            else        p_valid_q <= 1'b0;
                        end else if (accept) begin
                            f_q <= in_req;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (accept) begin
                            p_q       <= p_next;
                            p_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // ERROR is sticky until reset
                    mem_req_q <= 1'b0;
                    err_q     <= 1'b1;
                end
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = f_q.addr;
    assign mem_data_o = f_q.data;
    assign mem_be_o   = f_q.be;
    assign err_o      = err_q;
    assign empty_o    = (state_q == IDLE) && !p_valid_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_segre_sb_drain_ctrl.sv
// Directed and randomized bench for segre_sb_drain_ctrl against a FIFO-level reference model.
module tb_segre_sb_drain_ctrl;
    import segre_pkg::*;

    localparam int T  = 8;
    localparam int EW = 2 * WORD_SIZE + WORD_BYTES;
`ifdef SEGRE_DRAIN_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic                  clk_i = 1'b0;
    logic                  rsn_i;
    logic                  sb_valid_i;
    logic [WORD_SIZE-1:0]  sb_addr_i;
    logic [WORD_SIZE-1:0]  sb_data_i;
    logic [WORD_BYTES-1:0] sb_be_i;
    logic                  sb_ready_o;
    logic                  mem_req_o;
    logic [WORD_SIZE-1:0]  mem_addr_o;
    logic [WORD_SIZE-1:0]  mem_data_o;
    logic [WORD_BYTES-1:0] mem_be_o;
    logic                  mem_ack_i;
    logic                  empty_o;
    logic                  err_o;
    logic [1:0]            state_o;

    segre_sb_drain_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .sb_valid_i (sb_valid_i),
        .sb_addr_i  (sb_addr_i),
        .sb_data_i  (sb_data_i),
        .sb_be_i    (sb_be_i),
        .sb_ready_o (sb_ready_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_be_o   (mem_be_o),
        .mem_ack_i  (mem_ack_i),
        .empty_o    (empty_o),
        .err_o      (err_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: queue of accepted writes in order, head is the one on the bus.
    logic [EW-1:0] exp_q[$];
    int            m_wait = 0;
    bit            m_err  = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] merge_entry(input logic [EW-1:0] e, input logic [31:0] d,
                                                  input logic [3:0] b);
        logic [31:0] nd;
        nd = e[WORD_BYTES +: WORD_SIZE];
        for (int i = 0; i < 4; i++) begin
            if (b[i]) nd[8*i +: 8] = d[8*i +: 8];
        end
        return {e[EW-1 -: WORD_SIZE], nd, e[WORD_BYTES-1:0] | b};
    endfunction

    // One clock: apply inputs, check outputs against the model, advance the model.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit ack);
        logic [EW-1:0] head;
        logic [EW-1:0] tail;
        bit busy, m_ack, merge_ok, rdy;
        sb_valid_i = v;
        sb_addr_i  = a;
        sb_data_i  = d;
        sb_be_i    = b;
        mem_ack_i  = ack;
        @(negedge clk_i);
        busy     = !m_err && exp_q.size() > 0;
        m_ack    = busy && ack;
        merge_ok = 1'b0;
        if (MERGE && exp_q.size() == 2 && !m_ack) begin
            tail     = exp_q[1];
            merge_ok = (a[31:2] == tail[EW-1 -: 30]);
        end
        rdy = !m_err && (exp_q.size() < 2 || merge_ok);
        chk("sb_ready", {31'd0, sb_ready_o}, {31'd0, rdy});
        chk("mem_req", {31'd0, mem_req_o}, {31'd0, busy});
        chk("empty", {31'd0, empty_o}, {31'd0, !m_err && exp_q.size() == 0});
        chk("err", {31'd0, err_o}, {31'd0, m_err});
        if (busy) begin
            head = exp_q[0];
            chk("mem_addr", mem_addr_o, head[EW-1 -: WORD_SIZE]);
            chk("mem_data", mem_data_o, head[WORD_BYTES +: WORD_SIZE]);
            chk("mem_be", {28'd0, mem_be_o}, {28'd0, head[WORD_BYTES-1:0]});
            if (ack) begin
                void'(exp_q.pop_front());
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == T) m_err = 1'b1;
            end
        end
        if (v && rdy) begin
            if (merge_ok) exp_q[1] = merge_entry(exp_q[1], d, b);
            else          exp_q.push_back({a & ~32'h3, d, b});
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rsn_i      = 1'b1;
        sb_valid_i = 1'b0;
        mem_ack_i  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("ready_in_reset", {31'd0, sb_ready_o}, 32'd0);
            @(posedge clk_i);
            #1;
        end
        rsn_i = 1'b0;
        exp_q.delete();
        m_wait = 0;
        m_err  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        bit          rack;
        rsn_i      = 1'b1;
        sb_valid_i = 1'b0;
        sb_addr_i  = '0;
        sb_data_i  = '0;
        sb_be_i    = '0;
        mem_ack_i  = 1'b0;

        // reset state
        do_reset(2);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_empty", {31'd0, empty_o}, 32'd1);

        // single write, ack after 3 cycles
        step(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("single_req", {31'd0, mem_req_o}, 32'd1);
        chk("single_addr", mem_addr_o, 32'h100);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("single_empty", {31'd0, empty_o}, 32'd1);
        chk("single_idle_req", {31'd0, mem_req_o}, 32'd0);

        // back-to-back writes, no request gap on ack
        step(1'b1, 32'h100, 32'h11112222, 4'hF, 1'b0);
        step(1'b1, 32'h104, 32'h33334444, 4'hF, 1'b0);
        sb_valid_i = 1'b1;
        sb_addr_i  = 32'h108;
        #1;
        chk("b2b_ready", {31'd0, sb_ready_o}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("b2b_req", {31'd0, mem_req_o}, 32'd1);
        chk("b2b_addr", mem_addr_o, 32'h104);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("b2b_empty", {31'd0, empty_o}, 32'd1);

        // same-word request against the pending slot
        step(1'b1, 32'h300, 32'h12345678, 4'hF, 1'b0);
        step(1'b1, 32'h200, 32'h000000AA, 4'h1, 1'b0);
        sb_valid_i = 1'b1;
        sb_addr_i  = 32'h202;
        sb_data_i  = 32'h00BB0000;
        sb_be_i    = 4'h4;
        #1;
        chk("merge_ready", {31'd0, sb_ready_o}, {31'd0, MERGE});
        step(1'b1, 32'h202, 32'h00BB0000, 4'h4, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("merge_addr", mem_addr_o, 32'h200);
        chk("merge_data", mem_data_o, MERGE ? 32'h00BB00AA : 32'h000000AA);
        chk("merge_be", {28'd0, mem_be_o}, MERGE ? 32'd5 : 32'd1);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("merge_empty", {31'd0, empty_o}, 32'd1);

        // reset with F and P both held
        step(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0);
        step(1'b1, 32'h404, 32'h0BADF00D, 4'h3, 1'b0);
        do_reset(1);
        chk("rst_mid_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mid_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_mid_err", {31'd0, err_o}, 32'd0);

        // randomized traffic, ack always arrives before the timeout
        for (int i = 0; i < 400; i++) begin
            ra   = 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
            rack = (m_wait >= 5) ? 1'b1 : ($urandom_range(0, 2) == 0);
            step(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(1, 15)), rack);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("rand_drained", {31'd0, empty_o}, 32'd1);

        // timeout: no ack for T issue cycles
        step(1'b1, 32'h500, 32'h55555555, 4'hF, 1'b0);
        for (int i = 0; i < T; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("to_err", {31'd0, err_o}, 32'd1);
        chk("to_req", {31'd0, mem_req_o}, 32'd0);
        sb_valid_i = 1'b1;
        #1;
        chk("to_ready", {31'd0, sb_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600, 32'h1, 4'hF, 1'b1);
        chk("to_sticky", {31'd0, err_o}, 32'd1);
        do_reset(1);
        chk("to_clear_err", {31'd0, err_o}, 32'd0);
        chk("to_clear_empty", {31'd0, empty_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segre_sb_drain_ctrl.md
SEGRE_SB_DRAIN_CTRL -- requirements
Module: segre_sb_drain_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of cycles a memory write may wait for mem_ack_i.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock.
REQ-003 The block SHALL have port rsn_i, input, 1, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port sb_valid_i, input, 1, store-buffer drain request valid.
REQ-005 The block SHALL have ports sb_addr_i and sb_data_i, input, WORD_SIZE each, the drain address and data.
REQ-006 The block SHALL have port sb_be_i, input, WORD_BYTES, the byte enables.
REQ-007 The block SHALL have port sb_ready_o, output, 1, drain accept.
REQ-008 The block SHALL have port mem_req_o, output, 1, memory write request.
REQ-009 The block SHALL have ports mem_addr_o and mem_data_o, output, WORD_SIZE each, and port mem_be_o, output, WORD_BYTES.
REQ-010 The block SHALL have port mem_ack_i, input, 1, memory write complete.
REQ-011 The block SHALL have port empty_o, output, 1, no write held or in flight.
REQ-012 The block SHALL have port err_o, output, 1, sticky timeout error.

Function
REQ-013 The block SHALL hold two slots: F (in flight) and P (pending behind F).
REQ-014 The state machine SHALL have states IDLE (F empty), ISSUE (F valid, mem_req_o=1) and ERROR.
REQ-015 Acceptance SHALL be a cycle with sb_valid_i=1 and sb_ready_o=1.
REQ-016 sb_ready_o SHALL be !P.valid, plus the merge case in REQ-029, and SHALL be 0 in ERROR.
REQ-017 A request accepted in IDLE SHALL load F and drive mem_req_o=1 on the next cycle (latency 1).
REQ-018 A request accepted in ISSUE with no mem_ack_i SHALL load P.
REQ-019 On mem_ack_i in ISSUE: F retires; P is valid -> P moves to F and mem_req_o stays 1; else an accept in the same cycle loads F directly; else go to IDLE.
REQ-020 On mem_ack_i in ISSUE with P valid and a simultaneous accept, the incoming request SHALL load P.
REQ-021 mem_addr_o SHALL be {F.addr[WORD_SIZE-1:2],2'b00}; mem_data_o and mem_be_o SHALL come from F and stay stable while mem_req_o=1.
REQ-022 mem_ack_i outside ISSUE SHALL be ignored.
REQ-023 The timeout counter SHALL clear on entry to ISSUE and on every ack, and increment each ISSUE cycle without ack.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1 without ack, the block SHALL go to ERROR: err_o=1, mem_req_o=0, sb_ready_o=0, held until reset.
REQ-025 empty_o SHALL be !F.valid && !P.valid, and SHALL be 0 in ERROR.
REQ-026 Drain order SHALL equal acceptance order.

Reset
REQ-027 While rsn_i=1 at a clock edge: state=IDLE, F and P invalid, counter=0; outputs SHALL be mem_req_o=0, sb_ready_o=0 during reset, err_o=0, empty_o=1.
REQ-028 Reset mid-ISSUE SHALL drop F and P without completing them, and mem_req_o SHALL be 0 on the following cycle.

Configuration
REQ-029 With SEGRE_DRAIN_MERGE_EN defined: when P is valid, not moving to F this cycle, and sb_addr_i[WORD_SIZE-1:2]==P.addr[WORD_SIZE-1:2], sb_ready_o SHALL be 1; accepting SHALL overwrite the P byte lanes where sb_be_i=1 and set P.be |= sb_be_i.
REQ-030 Without SEGRE_DRAIN_MERGE_EN, P valid SHALL force sb_ready_o=0; F is never merged in either configuration.

Structure
REQ-031 segre_pkg SHALL hold WORD_BYTES=WORD_SIZE/8, drain_req_t {addr, data, be} and drain_state_t {IDLE, ISSUE, ERROR}.
REQ-032 The byte-lane merge SHALL be the sub-module segre_byte_merge, instantiated only under SEGRE_DRAIN_MERGE_EN.

Verification
REQ-033 Single write: accept addr 0x100, data 0xDEADBEEF, be 0xF -> next cycle mem_req_o=1, mem_addr_o=0x100; ack after 3 cycles -> IDLE, empty_o=1.
REQ-034 Back-to-back: accept writes to 0x100 and 0x104 without ack -> sb_ready_o=0; on ack, mem_addr_o=0x104 with no mem_req_o gap.
REQ-035 Merge (macro on): P holds 0x200/0x000000AA/be 0x1, then accept 0x202/0x00BB0000/be 0x4 -> P data 0x00BB00AA, be 0x5, one memory write. With the macro off, sb_ready_o stays 0.
REQ-036 Timeout: TIMEOUT_CYCLES=8 and no ack -> err_o=1 after 8 ISSUE cycles; mem_req_o=0, sb_ready_o=0 until reset.
REQ-037 Reset during ISSUE with P valid -> next cycle mem_req_o=0, empty_o=1, err_o=0.
